// File: rtl/mips_muldiv_pkg.sv
// Shared definitions for the MIPS multiply/divide unit: opcodes, FSM states
// and the LO value written on a divide by zero.
package mips_muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIX
    } state_e;

    // All-ones quotient for divide by zero; sliced to the datapath width (<= 128).
    localparam int                    MAX_WIDTH = 128;
    localparam logic [MAX_WIDTH-1:0]  DIVZ_LO   = '1;

endpackage

// File: rtl/mips_muldiv_core.sv
// Unsigned iterative engine: one shift-add (multiply) or restoring
// shift-subtract (divide) step per enabled cycle, accumulated in a 2W register.
module mips_muldiv_core
    import mips_muldiv_pkg::*;
#(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           i_load,
    input  logic           i_step,
    input  logic           i_div,
    input  logic [W-1:0]   i_a,
    input  logic [W-1:0]   i_b,
    output logic [2*W-1:0] o_acc,
    output logic [W-1:0]   o_quot,
    output logic [W-1:0]   o_rem
);

    logic [2*W-1:0] r_acc;
    logic [W-1:0]   r_opnd;
    logic           r_div;

    logic [W:0]     w_sum;
    logic [W:0]     w_rem_sh;
    logic [W:0]     w_diff;
    logic [2*W-1:0] w_next;

    // Upper half is the partial product (multiply) or partial remainder (divide).
    assign w_sum    = {1'b0, r_acc[2*W-1:W]} + {1'b0, r_opnd};
    assign w_rem_sh = {r_acc[2*W-1:W], r_acc[W-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_opnd};

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        w_next = {w_sum, r_acc[W-1:1]};
        if (!r_acc[0] && !r_div)
            w_next = {1'b0, r_acc[2*W-1:1]};
        else if (r_div)
            w_next = w_diff[W] ? {w_rem_sh[W-1:0], r_acc[W-2:0], 1'b0}
                               : {w_diff[W-1:0],   r_acc[W-2:0], 1'b1};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments only.
            r_acc  <= '0;
            r_opnd <= '0;
            r_div  <= 1'b0;
        end else if (i_load) begin
            r_div  <= i_div;
            r_opnd <= i_div ? i_b : i_a;
            r_acc  <= {{W{1'b0}}, (i_div ? i_a : i_b)};
        end else if (i_step) begin
            r_acc  <= w_next;
        end
    end

    assign o_acc  = r_acc;
    assign o_quot = r_acc[W-1:0];
    assign o_rem  = r_acc[2*W-1:W];

endmodule

// File: rtl/mips_muldiv_unit.sv
// MIPS MULT/MULTU/DIV/DIVU/MTHI/MTLO unit: sign handling, control FSM and the
// HI/LO result registers around the unsigned iterative core.
module mips_muldiv_unit
    import mips_muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] in_A,
    input  logic [DATA_WIDTH-1:0] in_B,
    input  logic                  cancel,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero,
    output logic [DATA_WIDTH-1:0] o_HI,
    output logic [DATA_WIDTH-1:0] o_LO
);

    localparam int W = DATA_WIDTH;

    state_e               r_state, w_next_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [W-1:0]         r_hi, r_lo, r_a_raw;
    logic                 r_done, r_dbz, r_dbz_pend;
    logic                 r_neg_q, r_neg_r, r_is_div;

    logic                 w_idle_req, w_muldiv, w_signed, w_div, w_accept;
    logic [W-1:0]         w_a_abs, w_b_abs, w_quot, w_rem, w_res_hi, w_res_lo;
    logic [2*W-1:0]       w_acc, w_prod;

    assign w_idle_req = (r_state == ST_IDLE) && start && !cancel;
    assign w_signed   = (op == OP_MULT) || (op == OP_DIV);
    assign w_div      = (op == OP_DIV)  || (op == OP_DIVU);
    assign w_muldiv   = w_signed || w_div || (op == OP_MULTU);
    assign w_accept   = w_idle_req && w_muldiv;

    assign w_a_abs = (w_signed && in_A[W-1]) ? -in_A : in_A;
    assign w_b_abs = (w_signed && in_B[W-1]) ? -in_B : in_B;

    mips_muldiv_core #(.W(W)) u_core (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_accept),
        .i_step (r_state == ST_RUN),
        .i_div  (w_div),
        .i_a    (w_a_abs),
        .i_b    (w_b_abs),
        .o_acc  (w_acc),
        .o_quot (w_quot),
        .o_rem  (w_rem)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next_state = ST_RUN;
            ST_RUN:  if (cancel) w_next_state = ST_IDLE;
                     else if (r_cnt == CNT_WIDTH'(1)) w_next_state = ST_FIX;
            ST_FIX:  w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // MIN / -1 needs no special case: |MIN| is 2^(W-1) unsigned and both signs cancel.
    assign w_prod = r_neg_q ? -w_acc : w_acc;

    always_comb begin
        w_res_hi = w_prod[2*W-1:W];
        w_res_lo = w_prod[W-1:0];
        if (r_is_div) begin
            if (r_dbz_pend) begin
                w_res_hi = r_a_raw;
                w_res_lo = DIVZ_LO[W-1:0];
            end else begin
                w_res_hi = r_neg_r ? -w_rem  : w_rem;
                w_res_lo = r_neg_q ? -w_quot : w_quot;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_a_raw    <= '0;
            r_done     <= 1'b0;
            r_dbz      <= 1'b0;
            r_dbz_pend <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_is_div   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_cnt      <= CNT_WIDTH'(W);
                r_neg_q    <= w_signed && (in_A[W-1] ^ in_B[W-1]);
                r_neg_r    <= w_signed && in_A[W-1];
                r_is_div   <= w_div;
                r_dbz_pend <= w_div && (in_B == '0);
                r_a_raw    <= in_A;
                r_dbz      <= 1'b0;
            end else if (r_state == ST_RUN) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_idle_req && (op == OP_MTHI)) r_hi <= in_A;
            if (w_idle_req && (op == OP_MTLO)) r_lo <= in_A;
            if ((r_state == ST_FIX) && !cancel) begin
                r_hi   <= w_res_hi;
                r_lo   <= w_res_lo;
                r_dbz  <= r_dbz_pend;
                r_done <= 1'b1;
            end
        end
    end

    assign busy        = (r_state != ST_IDLE);
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign o_HI        = r_hi;
    assign o_LO        = r_lo;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Bench for mips_muldiv_unit: arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed results (32-bit and 16-bit builds).
module tb_mips_muldiv_unit;
    import mips_muldiv_pkg::*;

    logic        clk, reset, start, start16, cancel;
    logic [2:0]  op;
    logic [31:0] in_A, in_B;
    logic        busy, done, dbz;
    logic [31:0] o_HI, o_LO;
    logic        busy16, done16, dbz16;
    logic [15:0] hi16, lo16;

    int n_cmp = 0;
    int n_bad = 0;

    mips_muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .in_A(in_A), .in_B(in_B),
        .cancel(cancel), .busy(busy), .done(done), .div_by_zero(dbz), .o_HI(o_HI), .o_LO(o_LO)
    );

    mips_muldiv_unit #(.DATA_WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .op(op), .in_A(in_A[15:0]), .in_B(in_B[15:0]),
        .cancel(cancel), .busy(busy16), .done(done16), .div_by_zero(dbz16), .o_HI(hi16), .o_LO(lo16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the MIPS definitions.
    function automatic void model_result(input logic [2:0] f_op, input logic [31:0] a, b,
                                         output logic [31:0] hi, lo, output logic dz);
        longint sp;
        int     sa, sb;
        dz = 1'b0;
        hi = '0;
        lo = '0;
        sa = a;
        sb = b;
        case (f_op)
            3'd0: begin sp = longint'(sa) * longint'(sb); {hi, lo} = 64'(sp); end
            3'd1: {hi, lo} = {32'b0, a} * {32'b0, b};
            3'd2, 3'd3: begin
                if (b == 0) begin
                    hi = a; lo = '1; dz = 1'b1;
                end else if (f_op == 3'd2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    hi = '0; lo = a;
                end else if (f_op == 3'd2) begin
                    lo = 32'(sa / sb); hi = 32'(sa % sb);
                end else begin
                    lo = a / b; hi = a % b;
                end
            end
            default: ;
        endcase
    endfunction

    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    logic        m_done, m_dbz, p_dbz;
    int          m_left;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_hi = '0; m_lo = '0; m_done = 0; m_dbz = 0; m_left = 0;
        end else begin
            m_done = 0;
            if (m_left > 0) begin
                if (cancel) m_left = 0;
                else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_hi = p_hi; m_lo = p_lo; m_dbz = p_dbz; m_done = 1;
                    end
                end
            end else if (start && !cancel) begin
                case (op)
                    3'd0, 3'd1, 3'd2, 3'd3: begin
                        model_result(op, in_A, in_B, p_hi, p_lo, p_dbz);
                        m_left = 33;
                        m_dbz  = 0;
                    end
                    3'd4: m_hi = in_A;
                    3'd5: m_lo = in_A;
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        check("busy", busy, m_left > 0);
        check("done", done, m_done);
        check("dbz",  dbz,  m_dbz);
        check("hi",   o_HI, m_hi);
        check("lo",   o_LO, m_lo);
    end

    task automatic wait_done(output int lat, output int bcnt);
        bcnt = busy ? 1 : 0;
        lat  = 200;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            if (done) begin lat = k; break; end
            if (busy) bcnt++;
        end
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, b, output int lat, output int bcnt);
        @(negedge clk); op = o; in_A = a; in_B = b; start = 1;
        @(negedge clk); start = 0;
        wait_done(lat, bcnt);
    endtask

    typedef struct { logic [2:0] o; logic [31:0] a, b; } vec_t;
    vec_t vecs[5] = '{
        '{3'd2, 32'd100,        32'hFFFF_FFF9},
        '{3'd3, 32'h8000_0000,  32'd3},
        '{3'd0, 32'h8000_0000,  32'h8000_0000},
        '{3'd2, 32'hFFFF_FF9C,  32'hFFFF_FFF9},
        '{3'd1, 32'h1234_5678,  32'h9ABC_DEF0}
    };

    initial begin
        int lat, bcnt;
        bit saw;
        reset = 1; start = 0; start16 = 0; cancel = 0; op = 0; in_A = 0; in_B = 0;
        #1 reset = 0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dbz",  dbz,  0);
        check("rst_hi",   o_HI, 0);
        check("rst_lo",   o_LO, 0);
        reset = 1;

        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, lat, bcnt);
        check("mult_lat", lat, 33);
        check("mult_busy_cycles", bcnt, 33);
        check("mult_hi", o_HI, 32'hFFFF_FFFF);
        check("mult_lo", o_LO, 32'hFFFF_FFF1);

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
        check("multu_hi", o_HI, 32'hFFFF_FFFE);
        check("multu_lo", o_LO, 32'h0000_0001);

        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
        check("div_lo", o_LO, 32'hFFFF_FFFD);
        check("div_hi", o_HI, 32'hFFFF_FFFF);

        run_op(OP_DIVU, 32'd7, 32'd0, lat, bcnt);
        check("divz_lat", lat, 33);
        check("divz_hi",  o_HI, 32'd7);
        check("divz_lo",  o_LO, 32'hFFFF_FFFF);
        check("divz_flag", dbz, 1);

        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
        check("ovf_lo", o_LO, 32'h8000_0000);
        check("ovf_hi", o_HI, 32'h0);
        check("ovf_flag", dbz, 0);

        foreach (vecs[i]) begin
            run_op(vecs[i].o, vecs[i].a, vecs[i].b, lat, bcnt);
            check("vec_lat", lat, 33);
        end

        @(negedge clk); op = OP_MTHI; in_A = 32'h1234; start = 1;
        @(posedge clk); #1;
        check("mthi_hi", o_HI, 32'h1234);
        check("mthi_busy", busy, 0);
        @(negedge clk); op = OP_MTLO; in_A = 32'h5678;
        @(posedge clk); #1;
        check("mtlo_lo", o_LO, 32'h5678);
        check("mtlo_busy", busy, 0);
        @(negedge clk); start = 0;

        @(negedge clk); op = OP_MULT; in_A = 32'd3; in_B = 32'd4; start = 1;
        @(negedge clk); start = 0;
        repeat (5) @(negedge clk);
        op = OP_MTLO; in_A = 32'hDEAD; start = 1;
        @(negedge clk); start = 0;
        wait_done(lat, bcnt);
        check("busy_mtlo_lo", o_LO, 32'd12);
        check("busy_mtlo_hi", o_HI, 32'd0);

        @(negedge clk); op = OP_MULT; in_A = 32'd6; in_B = 32'd7; start = 1;
        @(negedge clk); start = 0;
        repeat (9) @(negedge clk);
        cancel = 1;
        @(posedge clk); #1;
        check("cancel_busy", busy, 0);
        @(negedge clk); cancel = 0;
        saw = 0;
        repeat (40) begin @(posedge clk); #1; if (done) saw = 1; end
        check("cancel_no_done", saw, 0);
        check("cancel_hi", o_HI, 32'd0);
        check("cancel_lo", o_LO, 32'd12);

        @(negedge clk); op = OP_MULT; in_A = 32'd2; in_B = 32'd2; start = 1; cancel = 1;
        @(posedge clk); #1;
        check("cancel_start_busy", busy, 0);
        @(negedge clk); start = 0; cancel = 0; op = 3'd6; start = 1;
        @(posedge clk); #1;
        check("op6_busy", busy, 0);
        check("op6_lo", o_LO, 32'd12);
        @(negedge clk); start = 0;

        @(negedge clk); op = OP_MULT; in_A = 32'd6; in_B = 32'd7; start = 1;
        @(negedge clk); start = 0;
        repeat (9) @(negedge clk);
        @(posedge clk); #2 reset = 0;
        #1;
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_dbz",  dbz,  0);
        check("mrst_hi",   o_HI, 0);
        check("mrst_lo",   o_LO, 0);
        @(negedge clk); reset = 1;
        repeat (40) @(negedge clk);

        @(negedge clk); op = OP_MULTU; in_A = 32'h0000_FFFF; in_B = 32'd2; start16 = 1;
        @(negedge clk); start16 = 0;
        lat = 200;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            if (done16) begin lat = k; break; end
        end
        check("w16_lat", lat, 17);
        check("w16_hi", hi16, 16'h0001);
        check("w16_lo", lo16, 16'hFFFE);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
